// File: rtl/mac_pkg.sv
// Shared types and constants for the sequential multiply-accumulate unit.
package mac_pkg;

  typedef enum logic [1:0] {StIdle, StMul, StAcc, StOut} state_e;

  // Upper bound on accumulator width for the saturation constant helpers.
  localparam int unsigned MaxAccW = 512;

  // One radix-4 Booth digit per cycle over operands extended to data_w+2 bits.
  function automatic int unsigned booth_iter(int unsigned data_w);
    return data_w / 2 + 1;
  endfunction

  function automatic logic [MaxAccW-1:0] sat_max(int unsigned acc_w, logic is_signed);
    logic [MaxAccW-1:0] r;
    int unsigned        ones;
    r    = '0;
    ones = acc_w - (is_signed ? 32'd1 : 32'd0);
    for (int unsigned i = 0; i < MaxAccW; i++) begin
      if (i < ones) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MaxAccW-1:0] sat_min(int unsigned acc_w, logic is_signed);
    logic [MaxAccW-1:0] r;
    r = '0;
    if (is_signed) r[acc_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mac_seq_param_booth_r4_seq.sv
// Iterative radix-4 Booth multiplier: one digit per cycle, product held until next start.
module booth_r4_seq
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                is_signed,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] p
);

  localparam int unsigned ExtW  = DATA_W + 2;
  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned Iter  = booth_iter(DATA_W);
  localparam int unsigned CntW  = $clog2(Iter + 1);

  logic [ProdW-1:0] mcand_q, prod_q, pp;
  logic [ExtW-1:0]  mplr_q;
  logic             prev_q, busy_q, done_q;
  logic [CntW-1:0]  step_q;
  logic [ProdW-1:0] mcand_init;
  logic [ExtW-1:0]  mplr_init;

  // Modular arithmetic in 2*DATA_W bits is exact for both modes.
  always_comb begin
    mcand_init = {{DATA_W{is_signed & a[DATA_W-1]}}, a};
    mplr_init  = {{2{is_signed & b[DATA_W-1]}}, b};
  end

  always_comb begin
    pp = '0;
    case ({mplr_q[1:0], prev_q})
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      prev_q  <= 1'b0;
      prod_q  <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mcand_q <= mcand_init;
        mplr_q  <= mplr_init;
        prev_q  <= 1'b0;
        prod_q  <= '0;
        step_q  <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        prod_q  <= prod_q + pp;
        mcand_q <= mcand_q << 2;
        mplr_q  <= mplr_q >> 2;
        prev_q  <= mplr_q[1];
        step_q  <= step_q + CntW'(1);
        if (step_q == CntW'(Iter - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = prod_q;

endmodule

// File: rtl/mac_seq_param.sv
// Parametrised sequential MAC: Booth multiply, guard-bit accumulate, framed groups.
// Optional build macro MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module mac_seq_param
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 72,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_signed,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_e               state_q, state_d;
  logic                 live_q, signed_q, last_q, ovf_q;
  logic [ACC_W-1:0]     acc_q;
  logic [CNT_W-1:0]     count_q;

  logic                 accept, first, mul_signed, mul_busy, mul_done;
  logic [2*DATA_W-1:0]  mul_p;
  logic [ACC_W-1:0]     acc_base, prod_ext, acc_next;
  logic [ACC_W:0]       sum;
  logic                 c_out, c_msb, ovf_now;

  assign accept = in_valid & in_ready;
  // Count is cleared per group and saturates, so zero marks the first beat.
  assign first      = (count_q == '0);
  assign mul_signed = first ? in_signed : signed_q;

  booth_r4_seq #(
    .DATA_W (DATA_W)
  ) u_booth (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .a         (in_a),
    .b         (in_b),
    .is_signed (mul_signed),
    .busy      (mul_busy),
    .done      (mul_done),
    .p         (mul_p)
  );

`ifdef MAC_SATURATE_EN
  localparam logic [MaxAccW-1:0] SatMaxS = sat_max(ACC_W, 1'b1);
  localparam logic [MaxAccW-1:0] SatMinS = sat_min(ACC_W, 1'b1);
  localparam logic [MaxAccW-1:0] SatMaxU = sat_max(ACC_W, 1'b0);
`endif

  always_comb begin
    acc_base = first ? '0 : acc_q;
    if (signed_q) prod_ext = ACC_W'($signed(mul_p));
    else          prod_ext = ACC_W'(mul_p);
    sum      = {1'b0, acc_base} + {1'b0, prod_ext};
    c_out    = sum[ACC_W];
    c_msb    = acc_base[ACC_W-1] ^ prod_ext[ACC_W-1] ^ sum[ACC_W-1];
    ovf_now  = signed_q ? (c_msb ^ c_out) : c_out;
    acc_next = sum[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
    // Signed overflow needs like-signed operands, so the product sign gives the direction.
    if (ovf_now) begin
      if (!signed_q)                  acc_next = SatMaxU[ACC_W-1:0];
      else if (prod_ext[ACC_W-1])     acc_next = SatMinS[ACC_W-1:0];
      else                            acc_next = SatMaxS[ACC_W-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StMul;
      StMul:  if (mul_done && !mul_busy) state_d = StAcc;
      StAcc:  state_d = last_q ? StOut : StIdle;
      StOut:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = live_q && (state_q == StIdle);
    out_valid = (state_q == StOut);
    out_acc   = acc_q;
    out_count = count_q;
    out_ovf   = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= 1'b0;
      signed_q <= 1'b0;
      last_q   <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            last_q <= in_last;
            if (first) signed_q <= in_signed;
          end
        end
        StAcc: begin
          acc_q <= acc_next;
          if (count_q != '1) count_q <= count_q + CNT_W'(1);
          if (ovf_now) ovf_q <= 1'b1;
        end
        StOut: begin
          if (out_ready) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_param.sv
// Directed bench for mac_seq_param; a 72-bit and a 64-bit accumulator instance run in lockstep.
module tb_mac_seq_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_signed, in_last, out_ready;
  logic [31:0] in_a, in_b;

  logic        rdy72, vld72, ovf72, rdy64, vld64, ovf64;
  logic [71:0] acc72;
  logic [63:0] acc64;
  logic [15:0] cnt72, cnt64;

  int nvec = 0;
  int nerr = 0;
  int lat;

  always #5 clk = ~clk;

  mac_seq_param #(.DATA_W(32), .ACC_W(72), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy72), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_last(in_last), .out_valid(vld72), .out_ready(out_ready),
    .out_acc(acc72), .out_count(cnt72), .out_ovf(ovf72)
  );

  mac_seq_param #(.DATA_W(32), .ACC_W(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_last(in_last), .out_valid(vld64), .out_ready(out_ready),
    .out_acc(acc64), .out_count(cnt64), .out_ovf(ovf64)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic l);
    int n = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_last = l; in_valid = 1'b1;
    while (!rdy72 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 72'(rdy72), 72'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid is seen.
  task automatic wait_out(output int edges);
    edges = 0;
    while (!vld72 && edges < 100) begin
      @(posedge clk);
      #1 edges++;
    end
    if (!vld72) chk("out_valid_timeout", 72'(vld72), 72'd1);
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("consumed_valid", 72'(vld72), 72'd0);
    chk("consumed_count", 72'(cnt72), 72'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #1;
    chk("rst_in_ready",  72'(rdy72), 72'd0);
    chk("rst_out_valid", 72'(vld72), 72'd0);
    chk("rst_acc",       acc72,      72'd0);
    chk("rst_count",     72'(cnt72), 72'd0);
    chk("rst_ovf",       72'(ovf72), 72'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_release", 72'(rdy72), 72'd1);

    // Single signed beat with latency check
    send(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1);
    wait_out(lat);
    chk("latency",    72'(lat),   72'd19);
    chk("neg21_acc",  acc72,      -72'sd21);
    chk("neg21_cnt",  72'(cnt72), 72'd1);
    chk("neg21_ovf",  72'(ovf72), 72'd0);
    chk("neg21_rdy",  72'(rdy72), 72'd0);
    take();

    // Same operands unsigned then signed
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_out(lat);
    chk("uff_acc", acc72, 72'h00_FFFF_FFFE_0000_0001);
    take();
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_out(lat);
    chk("sff_acc", acc72, 72'd1);
    take();

    // Four-beat group; mode on later beats must be ignored
    send(32'd1000, 32'd1000, 1'b1, 1'b0);
    send(32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
    send(32'd5, 32'd5, 1'b0, 1'b0);
    send(32'd0, 32'd7, 1'b0, 1'b1);
    wait_out(lat);
    chk("grp4_acc", acc72,      72'd1000019);
    chk("grp4_cnt", 72'(cnt72), 72'd4);
    chk("grp4_ovf", 72'(ovf72), 72'd0);
    take();

    // Signed overflow at 64 bits, none at 72 bits
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    wait_out(lat);
    chk("s2p63_acc72", acc72,      72'h00_8000_0000_0000_0000);
    chk("s2p63_ovf72", 72'(ovf72), 72'd0);
`ifdef MAC_SATURATE_EN
    chk("s2p63_acc64", 72'(acc64), 72'h00_7FFF_FFFF_FFFF_FFFF);
`else
    chk("s2p63_acc64", 72'(acc64), 72'h00_8000_0000_0000_0000);
`endif
    chk("s2p63_ovf64", 72'(ovf64), 72'd1);
    chk("s2p63_cnt64", 72'(cnt64), 72'd2);
    take();

    // Unsigned overflow at 64 bits; then hold the result
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_out(lat);
`ifdef MAC_SATURATE_EN
    chk("u2ff_acc64", 72'(acc64), 72'h00_FFFF_FFFF_FFFF_FFFF);
`else
    chk("u2ff_acc64", 72'(acc64), 72'h00_FFFF_FFFC_0000_0002);
`endif
    chk("u2ff_ovf64", 72'(ovf64), 72'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_acc",   acc72,      72'h01_FFFF_FFFC_0000_0002);
      chk("hold_valid", 72'(vld72), 72'd1);
      chk("hold_ready", 72'(rdy72), 72'd0);
      chk("hold_cnt",   72'(cnt72), 72'd2);
    end
    take();
    chk("clr_ovf64", 72'(ovf64), 72'd0);
    send(32'd2, 32'd3, 1'b0, 1'b1);
    wait_out(lat);
    chk("fresh_acc", acc72,      72'd6);
    chk("fresh_cnt", 72'(cnt72), 72'd1);
    chk("fresh_ovf", 72'(ovf64), 72'd0);
    take();

    // Reset during multiply discards the partial group
    send(32'd100, 32'd100, 1'b1, 1'b0);
    send(32'd9, 32'd9, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 72'(rdy72), 72'd0);
    chk("midrst_acc",   acc72,      72'd0);
    chk("midrst_cnt",   72'(cnt72), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd4, 32'd5, 1'b1, 1'b1);
    wait_out(lat);
    chk("postrst_acc", acc72,      72'd20);
    chk("postrst_cnt", 72'(cnt72), 72'd1);
    chk("postrst_ovf", 72'(ovf72), 72'd0);
    take();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
